// File: rtl/keypad_matrix_emulator_if.sv
// Request port of the keypad matrix emulator: a sequencer asks for one key press.
// Ports: key_code/key_valid from the master; key_ready/key_done/key_err back from the slave.
// key_ready is high only while the emulator is idle; requests while busy are dropped.
interface keypad_matrix_emulator_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_done;
  logic       key_err;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready,
    input  key_done,
    input  key_err
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready,
    output key_done,
    output key_err
  );
endinterface

// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad model: returns the active-low column pattern of a pressed key.
// Latency: row-to-column path is combinational; contact closes the cycle after acceptance.
// Backpressure: key_ready high only in IDLE; key_valid while busy is ignored, not queued.
// Ports: clk, rst (sync, active-high), req (request interface, slave side),
//        lin_matriz (row drive in, active-low), col_matriz (column return, active-low),
//        contact (1 = switch closed, for debug/checking).
module keypad_matrix_emulator #(
  parameter int BOUNCE_CYCLES  = 8,
  parameter int HOLD_CYCLES    = 128,
  parameter int RELEASE_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  keypad_matrix_emulator_if.slave        req,
  input  logic [3:0]                     lin_matriz,
  output logic [3:0]                     col_matriz,
  output logic                           contact
);

  localparam int MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_BH > RELEASE_CYCLES) ? MAX_BH : RELEASE_CYCLES;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  // Terminal counts; B_LAST is unused when BOUNCE_CYCLES = 0 (state never entered).
  localparam logic [CW-1:0] B_LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUNCE,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    row_q;
  logic [3:0]    col_q;
  logic          ready_q;
  logic          done_q;
  logic          err_q;

  // {valid, row mask, col mask} for a key code.
  function automatic logic [8:0] key_masks(input logic [3:0] code);
    logic [8:0] m;
    m = {1'b0, 4'b1111, 4'b1111};
    case (code)
      4'h1: m = {1'b1, 4'b0111, 4'b0111};
      4'h2: m = {1'b1, 4'b0111, 4'b1011};
      4'h3: m = {1'b1, 4'b0111, 4'b1101};
      4'h4: m = {1'b1, 4'b1011, 4'b0111};
      4'h5: m = {1'b1, 4'b1011, 4'b1011};
      4'h6: m = {1'b1, 4'b1011, 4'b1101};
      4'h7: m = {1'b1, 4'b1101, 4'b0111};
      4'h8: m = {1'b1, 4'b1101, 4'b1011};
      4'h9: m = {1'b1, 4'b1101, 4'b1101};
      4'hA: m = {1'b1, 4'b1110, 4'b0111};
      4'h0: m = {1'b1, 4'b1110, 4'b1011};
      4'hB: m = {1'b1, 4'b1110, 4'b1101};
      default: m = {1'b0, 4'b1111, 4'b1111};
    endcase
    return m;
  endfunction

  logic [8:0] req_masks;
  assign req_masks = key_masks(req.key_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      contact <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      row_q   <= 4'b1111;
      col_q   <= 4'b1111;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          // ready_q is high whenever we are here, so key_valid alone accepts.
          if (req.key_valid) begin
            if (req_masks[8]) begin
              row_q   <= req_masks[7:4];
              col_q   <= req_masks[3:0];
              contact <= 1'b1;
              ready_q <= 1'b0;
              cnt     <= '0;
              state   <= (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_BOUNCE: begin
          if (cnt == B_LAST) begin
            cnt     <= '0;
            contact <= 1'b1;
            state   <= S_HOLD;
          end else begin
            // Closed on the first bounce cycle, so toggling tracks ~cnt[0].
            cnt     <= cnt + CW'(1);
            contact <= ~contact;
          end
        end
        S_HOLD: begin
          if (cnt == H_LAST) begin
            cnt     <= '0;
            contact <= 1'b0;
            state   <= S_RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == R_LAST) begin
            cnt     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Any driven row that hits the key's row connects the column, so a
  // non-one-hot drive behaves like the physical matrix.
  assign col_matriz = (contact && ((~lin_matriz & ~row_q) != 4'b0000)) ? col_q : 4'b1111;

  assign req.key_ready = ready_q;
  assign req.key_done  = done_q;
  assign req.key_err   = err_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Self-checking bench: two emulators (B=0/H=4/R=3 and B=4/H=5/R=3) driven by
// directed vectors; expected column patterns and pulse timing are hand-derived.
module tb_keypad_matrix_emulator;
  logic       clk;
  logic       rst;
  logic [3:0] lin0, lin1;
  logic [3:0] col0, col1;
  logic       contact0, contact1;

  int n_checks;
  int n_errors;

  keypad_matrix_emulator_if if0();
  keypad_matrix_emulator_if if1();

  keypad_matrix_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(4), .RELEASE_CYCLES(3)) u0 (
    .clk(clk), .rst(rst), .req(if0.slave),
    .lin_matriz(lin0), .col_matriz(col0), .contact(contact0)
  );

  keypad_matrix_emulator #(.BOUNCE_CYCLES(4), .HOLD_CYCLES(5), .RELEASE_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .req(if1.slave),
    .lin_matriz(lin1), .col_matriz(col1), .contact(contact1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int       toggles;
  int       closed_cnt;
  int       accepts;
  int       dones;
  int       acc2_cyc;
  int       done1_cyc;
  logic     prev_c;
  logic     seen;
  logic [3:0] exp_col;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    lin0 = 4'b0000; lin1 = 4'b0000;
    if0.key_code = 4'h1; if0.key_valid = 1'b1;  // dropped: coincident with rst
    if1.key_code = 4'h0; if1.key_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    if0.key_valid = 1'b0;

    // Reset state
    chk("rst_col0", col0, 4'b1111);
    chk("rst_col1", col1, 4'b1111);
    chk("rst_contact0", contact0, 1'b0);
    chk("rst_ready0", if0.key_ready, 1'b1);
    chk("rst_ready1", if1.key_ready, 1'b1);
    chk("rst_done0", if0.key_done, 1'b0);
    chk("rst_err0", if0.key_err, 1'b0);
    step();
    chk("rst_valid_dropped", contact0, 1'b0);

    // Key 8, B=0 H=4 R=3, row 1101
    lin0 = 4'b1101; if0.key_code = 4'h8; if0.key_valid = 1'b1;
    step();
    if0.key_valid = 1'b0;
    chk("k8_ready_low", if0.key_ready, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      exp_col = (i <= 4) ? 4'b1011 : 4'b1111;
      chk($sformatf("k8_col_c%0d", i), col0, exp_col);
      chk($sformatf("k8_nodone_c%0d", i), if0.key_done, 1'b0);
      lin0 = 4'b0111; #1;
      chk($sformatf("k8_otherrow_c%0d", i), col0, 4'b1111);
      lin0 = 4'b1101;
      step();
    end
    chk("k8_done", if0.key_done, 1'b1);
    chk("k8_ready_back", if0.key_ready, 1'b1);
    step();
    chk("k8_done_onecycle", if0.key_done, 1'b0);

    // Invalid code 0xC
    if0.key_code = 4'hC; if0.key_valid = 1'b1;
    step();
    if0.key_valid = 1'b0;
    chk("err_pulse", if0.key_err, 1'b1);
    chk("err_ready", if0.key_ready, 1'b1);
    chk("err_contact", contact0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (contact0 || !if0.key_ready || if0.key_err) seen = 1'b1;
    end
    chk("err_quiet_after", seen, 1'b0);

    // Bounce: key 1, B=4 H=5 R=3, row 0111
    lin1 = 4'b0111; if1.key_code = 4'h1; if1.key_valid = 1'b1;
    step();
    if1.key_valid = 1'b0;
    toggles = 0; closed_cnt = 0; prev_c = contact1;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 4) exp_col = (i % 2 == 1) ? 4'b0111 : 4'b1111;
      else if (i <= 9) exp_col = 4'b0111;
      else exp_col = 4'b1111;
      chk($sformatf("b1_col_c%0d", i), col1, exp_col);
      if (i >= 2 && i <= 5 && contact1 != prev_c) toggles++;
      if (contact1) closed_cnt++;
      prev_c = contact1;
      step();
    end
    chk("b1_toggles", toggles, 4);
    chk("b1_closed_cycles", closed_cnt, 7);
    chk("b1_done", if1.key_done, 1'b1);

    // Request held while busy: code 3 for 26 cycles
    step();
    lin1 = 4'b0111; if1.key_code = 4'h3; if1.key_valid = 1'b1;
    accepts = 0; dones = 0; acc2_cyc = -1; done1_cyc = -2;
    for (int c = 0; c < 32; c++) begin
      if (if1.key_done) begin
        dones++;
        if (dones == 1) done1_cyc = c;
      end
      if (if1.key_valid && if1.key_ready) begin
        accepts++;
        if (accepts == 2) acc2_cyc = c;
      end
      if (c == 25) if1.key_valid = 1'b0;
      step();
    end
    chk("held_accepts", accepts, 2);
    chk("held_dones", dones, 2);
    chk("held_b2b", acc2_cyc, done1_cyc);

    // Reset mid-HOLD of key 5 (row 1011, col 1011)
    lin1 = 4'b1011; if1.key_code = 4'h5; if1.key_valid = 1'b1;
    step();
    if1.key_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("k5_in_hold_col", col1, 4'b1011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("k5rst_contact", contact1, 1'b0);
    chk("k5rst_ready", if1.key_ready, 1'b1);
    chk("k5rst_done", if1.key_done, 1'b0);
    for (int r = 0; r < 4; r++) begin
      lin1 = ~(4'b0001 << r); #1;
      chk($sformatf("k5rst_col_r%0d", r), col1, 4'b1111);
    end
    lin1 = 4'b0000; #1;
    chk("k5rst_col_all", col1, 4'b1111);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (if1.key_done) seen = 1'b1;
    end
    chk("k5rst_no_done", seen, 1'b0);

    // Then key 0 (row 1110, col 1011)
    lin1 = 4'b1110; if1.key_code = 4'h0; if1.key_valid = 1'b1;
    step();
    if1.key_valid = 1'b0;
    chk("k0_contact", contact1, 1'b1);
    chk("k0_col_row0", col1, 4'b1011);
    lin1 = 4'b1101; #1;
    chk("k0_col_row1", col1, 4'b1111);
    lin1 = 4'b0000; #1;
    chk("k0_col_allrows", col1, 4'b1011);
    lin1 = 4'b1110;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (if1.key_done) seen = 1'b1;
    end
    chk("k0_done_seen", seen, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
